lif_neuron: RTL and testbench

Single leaky integrate-and-fire (LIF) neuron stage. It integrates an 8-bit input current once per enabled time step, applies a shift-based leak, and emits a one-cycle spike when the membrane potential reaches a programmable threshold. A refractory period follows each spike. It sits directly upstream of the chip output stage: `spike`, `refractory` and `membrane` are the values that stage drives onto `uo_out`.

---
 rtl/lif_neuron.sv | 127 ++++++++++++
 tb/tb_lif_neuron.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron stage.
// Each enabled step integrates an 8-bit current, applies a shift leak and fires a one-cycle spike
// when the potential reaches the threshold, followed by a fixed refractory period.
// Optional feature: define LIF_SPIKE_COUNTER_EN to build the 8-bit wrapping spike counter;
// otherwise spike_cnt is tied to zero.

module lif_neuron #(
    parameter int unsigned THRESH_DEFAULT = 200,
    parameter int unsigned LEAK_SHIFT     = 3,   // 1..7
    parameter int unsigned REFRACT        = 4    // 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       in_valid,
    input  logic [7:0] in_current,
    input  logic       thr_we,
    input  logic [7:0] thr_in,
    output logic [7:0] membrane,
    output logic       spike,
    output logic       refractory,
    output logic [7:0] spike_cnt
);

    typedef enum logic [0:0] {StInteg, StRefract} state_e;

    state_e     state_q, state_d;
    logic [7:0] v_q, v_d;
    logic [7:0] thr_q, thr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       spike_q, spike_d;

    logic [7:0] cur;
    logic [7:0] leak;
    logic [8:0] sum9;
    logic [7:0] sum_sat;

    // Integration datapath: V - (V >> LEAK_SHIFT) + I at 9 bits, saturated to 255.
    always_comb begin
        cur     = in_valid ? in_current : 8'd0;
        leak    = v_q >> LEAK_SHIFT;
        sum9    = {1'b0, v_q} - {1'b0, leak} + {1'b0, cur};
        sum_sat = sum9[8] ? 8'hFF : sum9[7:0];
    end

    // State register: FSM state, membrane, threshold, refractory counter and spike pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StInteg;
            v_q     <= 8'd0;
            thr_q   <= 8'(THRESH_DEFAULT);
            cnt_q   <= 4'd0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            thr_q   <= thr_d;
            cnt_q   <= cnt_d;
            spike_q <= spike_d;
        end
    end

    // Next-state logic; everything except the threshold holds while ena is low.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        spike_d = 1'b0;
        // Compare below uses thr_q, so a write in the same cycle only affects later steps.
        thr_d   = thr_we ? thr_in : thr_q;
        if (ena) begin
            unique case (state_q)
                StInteg: begin
                    if (sum_sat >= thr_q) begin
                        spike_d = 1'b1;
                        v_d     = 8'd0;
                        state_d = StRefract;
                        cnt_d   = 4'(REFRACT);
                    end else begin
                        v_d = sum_sat;
                    end
                end
                StRefract: begin
                    v_d   = 8'd0;
                    cnt_d = cnt_q - 4'd1;
                    // Leaving on count 1 yields exactly REFRACT ignored steps.
                    if (cnt_q == 4'd1) begin
                        state_d = StInteg;
                    end
                end
                default: begin
                    state_d = StInteg;
                end
            endcase
        end
    end

    // Outputs come straight from flops; no combinational input-to-output path.
    always_comb begin
        membrane   = v_q;
        spike      = spike_q;
        refractory = (state_q == StRefract);
    end

`ifdef LIF_SPIKE_COUNTER_EN
    logic [7:0] spike_cnt_q, spike_cnt_d;

    // Spike counter increments on each firing and wraps modulo 256.
    always_comb begin
        spike_cnt_d = spike_d ? spike_cnt_q + 8'd1 : spike_cnt_q;
    end

    // Spike counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spike_cnt_q <= 8'd0;
        end else begin
            spike_cnt_q <= spike_cnt_d;
        end
    end

    assign spike_cnt = spike_cnt_q;
`else
    assign spike_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_lif_neuron.sv
// Directed self-checking bench for lif_neuron with hand-computed expected values.

module tb_lif_neuron;

`ifdef LIF_SPIKE_COUNTER_EN
    localparam bit CntOn = 1'b1;
`else
    localparam bit CntOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic [7:0] in_current;
    logic       thr_we;
    logic [7:0] thr_in;
    logic [7:0] membrane;
    logic       spike;
    logic       refractory;
    logic [7:0] spike_cnt;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] exp_cnt = 8'd0;

    lif_neuron #(
        .THRESH_DEFAULT(200),
        .LEAK_SHIFT    (3),
        .REFRACT       (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_current(in_current),
        .thr_we    (thr_we),
        .thr_in    (thr_in),
        .membrane  (membrane),
        .spike     (spike),
        .refractory(refractory),
        .spike_cnt (spike_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    function automatic logic [7:0] cnt_exp();
        return CntOn ? exp_cnt : 8'd0;
    endfunction

    initial begin
        logic [7:0] ramp[5];
        logic [7:0] decay[4];
        ramp  = '{8'd50, 8'd94, 8'd133, 8'd167, 8'd197};
        decay = '{8'd83, 8'd73, 8'd64, 8'd56};

        rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; in_current = 8'd0;
        thr_we = 1'b0; thr_in = 8'd0;
        step(); step();
        chk("reset_membrane", membrane, 0);
        chk("reset_spike", spike, 0);
        chk("reset_refractory", refractory, 0);
        chk("reset_spike_cnt", spike_cnt, 0);

        // Constant drive of 50 from reset.
        rst_n = 1'b1; ena = 1'b1; in_valid = 1'b1; in_current = 8'd50;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ramp_membrane", membrane, ramp[i]);
            chk("ramp_no_spike", spike, 0);
        end
        step(); // S = 223
        exp_cnt++;
        chk("ramp_spike", spike, 1);
        chk("ramp_spike_membrane", membrane, 0);
        chk("ramp_spike_refr", refractory, 1);
        chk("ramp_spike_cnt", spike_cnt, cnt_exp());
        step(); // refractory step 1
        chk("spike_one_cycle", spike, 0);
        chk("refr_step1", refractory, 1);

        // Enable gating in the middle of refractory.
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gate_spike", spike, 0);
            chk("gate_refr", refractory, 1);
            chk("gate_membrane", membrane, 0);
        end
        ena = 1'b1;
        step();
        chk("refr_step2", refractory, 1);
        step();
        chk("refr_step3", refractory, 1);
        step();
        chk("refr_step4_done", refractory, 0);
        chk("refr_membrane", membrane, 0);
        step();
        chk("resume_50", membrane, 50);
        step();
        chk("resume_94", membrane, 94);

        // Leak only.
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("leak_membrane", membrane, decay[i]);
            chk("leak_no_spike", spike, 0);
        end

        // 56 - 7 + 210 saturates to 255, fires.
        in_valid = 1'b1; in_current = 8'd210;
        step();
        exp_cnt++;
        chk("sat210_spike", spike, 1);
        chk("sat210_refr", refractory, 1);
        chk("sat210_cnt", spike_cnt, cnt_exp());

        // Threshold write with ena low, then reset while refractory.
        ena = 1'b0; thr_we = 1'b1; thr_in = 8'd255;
        step();
        thr_we = 1'b0;
        chk("pre_reset_refr", refractory, 1);
        rst_n = 1'b0;
        step();
        exp_cnt = 8'd0;
        chk("midrst_membrane", membrane, 0);
        chk("midrst_spike", spike, 0);
        chk("midrst_refr", refractory, 0);
        chk("midrst_cnt", spike_cnt, 0);
        rst_n = 1'b1; ena = 1'b1;
        step(); // 210 >= 200 only if threshold was restored
        exp_cnt++;
        chk("midrst_fire", spike, 1);
        chk("midrst_fire_cnt", spike_cnt, cnt_exp());

        // Threshold write coinciding with a compare uses the old value.
        rst_n = 1'b0;
        step();
        exp_cnt = 8'd0;
        rst_n = 1'b1; thr_we = 1'b1; thr_in = 8'd255; in_current = 8'd210;
        step();
        thr_we = 1'b0;
        exp_cnt++;
        chk("samecyc_old_thr", spike, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("samecyc_refr_membrane", membrane, 0);
        end
        step();
        chk("new_thr_no_spike", spike, 0);
        chk("new_thr_membrane", membrane, 210);
        in_current = 8'd255;
        step(); // 210 - 26 + 255 saturates
        exp_cnt++;
        chk("sat_after_210", spike, 1);
        chk("sat_after_210_cnt", spike_cnt, cnt_exp());

        // Saturation from reset with threshold 255.
        rst_n = 1'b0;
        step();
        exp_cnt = 8'd0;
        rst_n = 1'b1; ena = 1'b0; thr_we = 1'b1; thr_in = 8'd255;
        step();
        thr_we = 1'b0; ena = 1'b1; in_current = 8'd255;
        step();
        exp_cnt++;
        chk("sat255_spike", spike, 1);
        chk("sat255_membrane", membrane, 0);
        chk("sat255_cnt", spike_cnt, cnt_exp());
        in_valid = 1'b0;
        repeat (4) step();
        in_valid = 1'b1; in_current = 8'd254;
        step();
        chk("thr255_254_no_spike", spike, 0);
        chk("thr255_254_membrane", membrane, 254);

        // Threshold 0: fires on every INTEG step, counter wraps.
        ena = 1'b0; thr_we = 1'b1; thr_in = 8'd0; in_valid = 1'b0;
        step();
        thr_we = 1'b0; ena = 1'b1;
        for (int g = 0; g < 260; g++) begin
            step();
            exp_cnt++;
            chk("thr0_spike", spike, 1);
            chk("thr0_cnt", spike_cnt, cnt_exp());
            for (int i = 0; i < 4; i++) begin
                step();
                chk("thr0_gap_spike", spike, 0);
                chk("thr0_gap_refr", refractory, (i < 3) ? 1 : 0);
            end
        end
        chk("thr0_wrapped_cnt", spike_cnt, CntOn ? 5 : 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
